alu_sequencer: RTL
==================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 8, giving the operand and result width in bits.
REQ-002 SHALL have parameter CNT_W, default 16, giving the width of the completed-operation counter.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 Port: clk  input  1  rising-edge clock for all state.
REQ-005 Port: rst_n  input  1  asynchronous active-low reset.
REQ-006 Port: req_valid  input  1  request present.
REQ-007 Port: req_ready  output  1  sequencer accepts a request this cycle.
REQ-008 Port: req_op  input  4  opcode, alu_op_t encoding (NOP=0 ... CLEAR_FLAGS=15).
REQ-009 Port: req_a  input  WORD_SIZE  operand A.
REQ-010 Port: req_b  input  WORD_SIZE  operand B.
REQ-011 Port: req_chain  input  1  substitute the last result for operand A; ignored unless ALU_SEQ_CHAIN_EN is defined.
REQ-012 Port: rsp_valid  output  1  response present.
REQ-013 Port: rsp_ready  input  1  consumer takes the response.
REQ-014 Port: rsp_result  output  WORD_SIZE  ALU result.
REQ-015 Port: rsp_op  output  4  opcode of the response.
REQ-016 Port: flags  output  4  architectural flags {Z,S,C,O}, bits 3..0.
REQ-017 Port: busy  output  1  high when state is not IDLE.
REQ-018 Port: op_count  output  CNT_W  number of completed responses, saturating.

Function
REQ-019 SHALL implement the FSM states IDLE, EXEC and RESP.
REQ-020 SHALL assert req_ready only in IDLE; on req_valid&&req_ready it SHALL latch op, A and B, then go to EXEC.
REQ-021 In EXEC, SHALL drive the ALU from the latched registers only, capture output_C into rsp_result and the ALU flags[7:4] into the flag staging register, then go to RESP.
REQ-022 SHALL hold rsp_valid high in RESP; rsp_result and rsp_op SHALL stay stable until rsp_valid&&rsp_ready, then go to IDLE.
REQ-023 Latency SHALL be exactly 2 cycles from the accepting edge to rsp_valid high; maximum throughput is one operation per 3 cycles.
REQ-024 A request arriving while in RESP or EXEC SHALL wait; req_ready=0 there, including the cycle a response handshakes.
REQ-025 flags SHALL update on the response handshake: NOP leaves flags unchanged; CLEAR_FLAGS sets 0000; every other op loads the captured ALU flags.
REQ-026 NOP and CLEAR_FLAGS SHALL return rsp_result=0; CMP and TEST SHALL return rsp_result=latched A.
REQ-027 SHALL present the architectural carry (flags[1]) to the ALU carry path for ADC and SBB.
REQ-028 op_count SHALL increment on each response handshake and saturate at all-ones with no wrap.

Reset
REQ-029 On rst_n low, SHALL immediately enter IDLE and force req_ready=1 (from the first clock after release), rsp_valid=0, rsp_result=0, rsp_op=0, flags=0000, busy=0, op_count=0, with the last-result register at 0.
REQ-030 A reset asserted in EXEC or RESP SHALL discard the in-flight operation without any flag update.

Configuration
REQ-031 Macro ALU_SEQ_CHAIN_EN defined: if req_chain=1 at accept, operand A SHALL be the last handshaked rsp_result (0 after reset).
REQ-032 Macro ALU_SEQ_CHAIN_EN undefined: req_chain is ignored and no last-result register is built.

Structure
REQ-033 Package alu_pkg SHALL hold alu_op_t, the flag bit index constants (Z, S, C, O) and the sequencer state enum.
REQ-034 SHALL instantiate exactly one sub-module, the existing alu, with WORD_SIZE passed through.

Verification
REQ-035 ADD A=10, B=30 -> rsp_valid 2 cycles after accept, rsp_result=40, flags=0000 after handshake.
REQ-036 ADD 255+1, then ADC 1+0 -> first gives 0 with Z=1, C=1; second gives 2.
REQ-037 SUB 127-(-1) with rsp_ready low for 5 cycles -> rsp_result=128 stable, req_ready=0 throughout; after handshake, flags S=1, C=1, O=1.
REQ-038 CLEAR_FLAGS after the overflow case -> flags=0000, rsp_result=0; a following NOP leaves flags=0000.
REQ-039 With ALU_SEQ_CHAIN_EN: MOV B=77, then ADD chain B=3 -> 80; without the macro, the same sequence with A=0 -> 3.
REQ-040 rst_n pulsed low during EXEC -> all outputs at reset values, no response issued; preload op_count to all-ones minus 1 and run two operations -> op_count reaches 0xFFFF and holds.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the ALU sequencer: opcode encoding, flag bit positions and FSM states.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_NOP         = 4'd0,
        OP_ADD         = 4'd1,
        OP_ADC         = 4'd2,
        OP_SUB         = 4'd3,
        OP_SBB         = 4'd4,
        OP_AND         = 4'd5,
        OP_OR          = 4'd6,
        OP_XOR         = 4'd7,
        OP_NOT         = 4'd8,
        OP_SHL         = 4'd9,
        OP_SHR         = 4'd10,
        OP_MOV         = 4'd11,
        OP_CMP         = 4'd12,
        OP_TEST        = 4'd13,
        OP_INC         = 4'd14,
        OP_CLEAR_FLAGS = 4'd15
    } alu_op_t;

    localparam int FLAG_Z = 3;
    localparam int FLAG_S = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_O = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } seq_state_t;

endpackage

// File: rtl/alu.sv
// Combinational ALU: flags[7:4] are the freshly computed {Z,S,C,O}, flags[3:0] echo flags_in.
module alu
    import alu_pkg::*;
#(
    parameter int WORD_SIZE = 8
) (
    input  alu_op_t              op,
    input  logic [WORD_SIZE-1:0] input_A,
    input  logic [WORD_SIZE-1:0] input_B,
    input  logic [3:0]           flags_in,
    output logic [WORD_SIZE-1:0] output_C,
    output logic [7:0]           flags
);

    localparam int M = WORD_SIZE - 1;

    logic [WORD_SIZE:0]   ext;
    logic [WORD_SIZE-1:0] res;
    logic                 cin;
    logic                 c;
    logic                 o;
    logic                 upd;

    always_comb begin
        ext      = '0;
        res      = '0;
        c        = 1'b0;
        o        = 1'b0;
        upd      = 1'b1;
        cin      = flags_in[FLAG_C];
        output_C = '0;
        case (op)
            OP_ADD, OP_ADC: begin
                ext = {1'b0, input_A} + {1'b0, input_B}
                    + {{WORD_SIZE{1'b0}}, (op == OP_ADC) ? cin : 1'b0};
                res = ext[M:0];
                c   = ext[WORD_SIZE];
                o   = (input_A[M] == input_B[M]) && (res[M] != input_A[M]);
            end
            OP_SUB, OP_SBB, OP_CMP: begin
                // C is the borrow out of the unsigned subtraction
                ext = {1'b0, input_A} - {1'b0, input_B}
                    - {{WORD_SIZE{1'b0}}, (op == OP_SBB) ? cin : 1'b0};
                res = ext[M:0];
                c   = ext[WORD_SIZE];
                o   = (input_A[M] != input_B[M]) && (res[M] != input_A[M]);
            end
            OP_AND, OP_TEST: res = input_A & input_B;
            OP_OR:           res = input_A | input_B;
            OP_XOR:          res = input_A ^ input_B;
            OP_NOT:          res = ~input_A;
            OP_SHL: begin
                res = {input_A[M-1:0], 1'b0};
                c   = input_A[M];
            end
            OP_SHR: begin
                res = {1'b0, input_A[M:1]};
                c   = input_A[0];
            end
            OP_MOV:          res = input_B;
            OP_INC: begin
                ext = {1'b0, input_A} + {{WORD_SIZE{1'b0}}, 1'b1};
                res = ext[M:0];
                c   = ext[WORD_SIZE];
                o   = ~input_A[M] & res[M];
            end
            default:         upd = 1'b0;
        endcase
        output_C = ((op == OP_CMP) || (op == OP_TEST)) ? input_A : res;
        flags[3:0]          = flags_in;
        flags[4 + FLAG_Z]   = upd & (res == '0);
        flags[4 + FLAG_S]   = upd & res[M];
        flags[4 + FLAG_C]   = upd & c;
        flags[4 + FLAG_O]   = upd & o;
    end

endmodule

// File: rtl/alu_sequencer.sv
// Three-state request/response wrapper around alu with architectural flags and a saturating op counter.
// Optional operand-A chaining from the last response is built only with ALU_SEQ_CHAIN_EN defined.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int WORD_SIZE = 8,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [3:0]           req_op,
    input  logic [WORD_SIZE-1:0] req_a,
    input  logic [WORD_SIZE-1:0] req_b,
    input  logic                 req_chain,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [WORD_SIZE-1:0] rsp_result,
    output logic [3:0]           rsp_op,
    output logic [3:0]           flags,
    output logic                 busy,
    output logic [CNT_W-1:0]     op_count
);

    seq_state_t           state_q, state_d;
    alu_op_t              op_q;
    logic [WORD_SIZE-1:0] a_q, b_q, result_q, a_src, alu_c;
    logic [7:0]           alu_flags;
    logic [3:0]           stage_q, flags_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 accept, handshake;

    assign req_ready  = (state_q == ST_IDLE);
    assign rsp_valid  = (state_q == ST_RESP);
    assign busy       = (state_q != ST_IDLE);
    assign accept     = req_valid && req_ready;
    assign handshake  = rsp_valid && rsp_ready;
    assign rsp_result = result_q;
    assign rsp_op     = op_q;
    assign flags      = flags_q;
    assign op_count   = cnt_q;

`ifdef ALU_SEQ_CHAIN_EN
    logic [WORD_SIZE-1:0] last_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         last_q <= '0;
        else if (handshake) last_q <= result_q;
    end

    assign a_src = req_chain ? last_q : req_a;
`else
    logic unused_chain;
    assign unused_chain = req_chain;
    assign a_src        = req_a;
`endif

    alu #(.WORD_SIZE(WORD_SIZE)) u_alu (
        .op       (op_q),
        .input_A  (a_q),
        .input_B  (b_q),
        .flags_in (flags_q),
        .output_C (alu_c),
        .flags    (alu_flags)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept)    state_d = ST_EXEC;
            ST_EXEC:                state_d = ST_RESP;
            ST_RESP: if (handshake) state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= OP_NOP;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            stage_q  <= '0;
            flags_q  <= '0;
            cnt_q    <= '0;
        end else begin
            if (accept) begin
                op_q <= alu_op_t'(req_op);
                a_q  <= a_src;
                b_q  <= req_b;
            end
            if (state_q == ST_EXEC) begin
                result_q <= alu_c;
                // NOP stages the echoed current flags so the handshake leaves them unchanged
                stage_q  <= (op_q == OP_NOP) ? alu_flags[3:0] : alu_flags[7:4];
            end
            if (handshake) begin
                flags_q <= stage_q;
                if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule
